// File: rtl/edge_delay_checker.sv
// -----------------------------------------------------------------------------
// edge_delay_checker
//
// Purpose:
//   Receiving end of an enable -> delayed-trigger handshake. Measures the
//   number of clock edges between the edge that samples a rising `enable`
//   and the edge that samples the following rising `trigger`. The measured
//   delay is compared against EXPECTED, and saturating pass/fail tallies are
//   kept. A measurement that runs to TIMEOUT counts is abandoned.
//
// Parameters:
//   EXPECTED  required delay in clock edges
//   CNT_W     width of the delay counter and meas_cnt
//   TIMEOUT   count at which a measurement is abandoned
//             (EXPECTED < TIMEOUT <= 2**CNT_W-1)
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   start strobe, rising edge opens a measurement
//   trigger     in   response, rising edge closes a measurement
//   busy        out  measurement open
//   meas_valid  out  one-cycle pulse on completion
//   meas_cnt    out  measured delay, held until the next completion
//   match       out  meas_cnt == EXPECTED, updated with meas_valid
//   timeout     out  one-cycle pulse when a measurement is abandoned
//   restart     out  one-cycle pulse on an enable edge while measuring
//   stray       out  one-cycle pulse on a trigger edge while idle
//   pass_count  out  saturating count of matching completions
//   fail_count  out  saturating count of mismatching completions + timeouts
// -----------------------------------------------------------------------------
module edge_delay_checker #(
    parameter int EXPECTED = 5,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             trigger,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             match,
    output logic             timeout,
    output logic             restart,
    output logic             stray,
    output logic [7:0]       pass_count,
    output logic [7:0]       fail_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXPECTED);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

    // Saturating 8-bit increment: tallies stop at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enable_q, trigger_q;
    logic             busy_q, busy_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
    logic             match_q, match_d;
    logic             timeout_q, timeout_d;
    logic             restart_q, restart_d;
    logic             stray_q, stray_d;
    logic [7:0]       pass_q, pass_d;
    logic [7:0]       fail_q, fail_d;

    logic             en_edge_s;
    logic             trig_edge_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // The history flops reset to 1 so a level already high at reset release
    // is not mistaken for a rising edge.
    assign en_edge_s   = enable & ~enable_q;
    assign trig_edge_s = trigger & ~trigger_q;
    // cnt_q never exceeds TIMEOUT-1, so the increment cannot overflow CNT_W.
    assign cnt_inc_s   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state and registered-output computation for the IDLE/MEAS FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        meas_valid_d = 1'b0;
        meas_cnt_d   = meas_cnt_q;
        match_d      = match_q;
        timeout_d    = 1'b0;
        restart_d    = 1'b0;
        stray_d      = 1'b0;
        pass_d       = pass_q;
        fail_d       = fail_q;

        case (state_q)
            ST_IDLE: begin
                // Enable wins over a coincident trigger edge: no stray then.
                if (en_edge_s) begin
                    state_d = ST_MEAS;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (trig_edge_s) begin
                    stray_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEAS: begin
                if (en_edge_s) begin
                    // Re-arm; a coincident trigger edge is ignored.
                    restart_d = 1'b1;
                    cnt_d     = {CNT_W{1'b0}};
                end else if (trig_edge_s) begin
                    state_d      = ST_IDLE;
                    meas_valid_d = 1'b1;
                    meas_cnt_d   = cnt_inc_s;
                    match_d      = (cnt_inc_s == EXP_CNT);
                    if (cnt_inc_s == EXP_CNT) begin
                        pass_d = sat_inc8(pass_q);
                    end else begin
                        fail_d = sat_inc8(fail_q);
                    end
                end else if (cnt_inc_s == TO_CNT) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    fail_d    = sat_inc8(fail_q);
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        // busy reflects the state being entered so it rises on the edge that
        // samples the enable rise and falls on the completing edge.
        busy_d = (state_d == ST_MEAS);
    end

    // State, counter, edge history and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            enable_q     <= 1'b1;
            trigger_q    <= 1'b1;
            busy_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            meas_cnt_q   <= {CNT_W{1'b0}};
            match_q      <= 1'b0;
            timeout_q    <= 1'b0;
            restart_q    <= 1'b0;
            stray_q      <= 1'b0;
            pass_q       <= 8'd0;
            fail_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            enable_q     <= enable;
            trigger_q    <= trigger;
            busy_q       <= busy_d;
            meas_valid_q <= meas_valid_d;
            meas_cnt_q   <= meas_cnt_d;
            match_q      <= match_d;
            timeout_q    <= timeout_d;
            restart_q    <= restart_d;
            stray_q      <= stray_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
        end
    end

    assign busy       = busy_q;
    assign meas_valid = meas_valid_q;
    assign meas_cnt   = meas_cnt_q;
    assign match      = match_q;
    assign timeout    = timeout_q;
    assign restart    = restart_q;
    assign stray      = stray_q;
    assign pass_count = pass_q;
    assign fail_count = fail_q;

endmodule
